// File: rtl/gs_recip_seed_pipe.sv
// Pipelined reciprocal-seed generator feeding the first Goldschmidt multiply.
// Stages: leading-one detect -> seed table lookup -> scale/saturate, with valid/ready flow control.
module gs_recip_seed_pipe #(
  parameter int W = 16,
  parameter int F = 8,
  parameter int P = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] d_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r_out,
  output logic         dz,
  output logic         sat
);
  localparam int PW = $clog2(W);
  // Wide enough to hold the signed shift 2F-p-P-1 over its full range.
  localparam int SW = $clog2(2*W + P + 2) + 1;

  logic                 v1_q, v2_q, v3_q;
  logic [PW-1:0]        p1_q;
  logic [P-1:0]         m1_q;
  logic                 z1_q;
  logic [P:0]           l2_q;
  logic signed [SW-1:0] s2_q;
  logic                 z2_q;
  logic [W-1:0]         r3_q;
  logic                 dz3_q, sat3_q;

  logic adv1, adv2;

  assign adv2     = !v3_q || out_ready;
  assign adv1     = !v2_q || adv2;
  assign in_ready = !v1_q || adv1;

  logic [PW-1:0] p_d;
  logic [P-1:0]  m_d;

  always_comb begin
    p_d = '0;
    for (int i = 0; i < W; i++) begin
      if (d_in[i]) p_d = PW'(i);
    end
    // Bits below the leading one, zero-filled once they run past bit 0.
    m_d = P'({d_in, {P{1'b0}}} >> p_d);
  end

  logic [P:0] lut [2**P];

  for (genvar g = 0; g < 2**P; g++) begin : g_lut
    localparam int unsigned LV = (2**(2*P+2)) / (2**(P+1) + 2*g + 1);
    assign lut[g] = (P+1)'(LV);
  end

  logic [P:0]           l_d;
  logic signed [SW-1:0] s_d;

  assign l_d = lut[m1_q];
  assign s_d = SW'(2*F - P - 1) - SW'(p1_q);

  logic [W+P:0]  wide;
  logic [SW-1:0] sh;
  logic          ovf;
  logic [W-1:0]  r_d;
  logic          sat_d;

  always_comb begin
    sh   = '0;
    wide = '0;
    ovf  = 1'b0;
    if (s2_q[SW-1]) begin
      sh   = -s2_q;
      wide = {{W{1'b0}}, l2_q} >> sh;
    end else begin
      sh   = s2_q;
      ovf  = (sh >= SW'(W));
      wide = {{W{1'b0}}, l2_q} << sh;
    end
    sat_d = ovf || (|wide[W+P:W]);
    r_d   = sat_d ? '1 : wide[W-1:0];
    if (z2_q) begin
      r_d   = '1;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p1_q   <= '0;
      m1_q   <= '0;
      z1_q   <= 1'b0;
      l2_q   <= '0;
      s2_q   <= '0;
      z2_q   <= 1'b0;
      r3_q   <= '0;
      dz3_q  <= 1'b0;
      sat3_q <= 1'b0;
    end else begin
      if (in_ready) v1_q <= in_valid;
      if (in_ready && in_valid) begin
        p1_q <= p_d;
        m1_q <= m_d;
        z1_q <= (d_in == '0);
      end
      if (adv1) v2_q <= v1_q;
      if (adv1 && v1_q) begin
        l2_q <= l_d;
        s2_q <= s_d;
        z2_q <= z1_q;
      end
      if (adv2) v3_q <= v2_q;
      if (adv2 && v2_q) begin
        r3_q   <= r_d;
        dz3_q  <= z2_q;
        sat3_q <= sat_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign r_out     = r3_q;
  assign dz        = dz3_q;
  assign sat       = sat3_q;

endmodule
